// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner and the calculator core.
//   kp_state_t   : scanner FSM state encoding
//   CMD_*        : 4-bit command codes seen by the calculator
//   key_code()   : (row index, column index) -> command code
//   key_unused() : true for the one matrix position with no command
package keypad_pkg;

    localparam int unsigned KP_ROWS = 4;
    localparam int unsigned KP_COLS = 4;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_EMIT     = 2'd2,
        ST_RELEASE  = 2'd3
    } kp_state_t;

    localparam logic [3:0] CMD_ADD  = 4'd10;
    localparam logic [3:0] CMD_SUB  = 4'd11;
    localparam logic [3:0] CMD_MUL  = 4'd12;
    localparam logic [3:0] CMD_IDLE = 4'd13;
    localparam logic [3:0] CMD_EQ   = 4'd14;
    localparam logic [3:0] CMD_CLR  = 4'd15;

    // Matrix position to command; the unused position maps to idle.
    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = CMD_IDLE;
        case ({row, col})
            4'h0:    code = 4'd1;
            4'h1:    code = 4'd2;
            4'h2:    code = 4'd3;
            4'h3:    code = CMD_ADD;
            4'h4:    code = 4'd4;
            4'h5:    code = 4'd5;
            4'h6:    code = 4'd6;
            4'h7:    code = CMD_SUB;
            4'h8:    code = 4'd7;
            4'h9:    code = 4'd8;
            4'hA:    code = 4'd9;
            4'hB:    code = CMD_MUL;
            4'hC:    code = CMD_CLR;
            4'hD:    code = 4'd0;
            4'hE:    code = CMD_EQ;
            default: code = CMD_IDLE;
        endcase
        return code;
    endfunction

    function automatic logic key_unused(input logic [1:0] row, input logic [1:0] col);
        return (row == 2'd3) && (col == 2'd3);
    endfunction

endpackage

// File: rtl/keypad_scanner_row_sync.sv
// Two-flop synchronizer for asynchronous inputs, resetting to all-ones
// (idle level of pulled-up, active-low lines).
//   clock, reset : system clock, async active-high reset
//   i_d          : asynchronous input bus
//   o_q          : synchronized output bus (2-cycle latency)
module row_sync #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: rotates the column drive, debounces a single
// pressed key, emits one registered command strobe per press, then waits for
// a debounced full release before scanning again.
//   clock, reset : system clock, async active-high reset
//   rows         : matrix rows, active-low, asynchronous
//   cols         : one-hot active-low column drive
//   cmd          : command code, CMD_IDLE except in the emit cycle
//   key_valid    : one-cycle strobe qualifying cmd
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned DEBOUNCE_CNT = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] cmd,
    output logic       key_valid
);

    localparam int unsigned CNT_SRC = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
    localparam int unsigned CNT_W   = $clog2(CNT_SRC) + 1;
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = '1;

    kp_state_t        r_state;
    logic [CNT_W-1:0] r_scan_cnt;
    logic [CNT_W-1:0] r_db_cnt;
    logic [3:0]       r_cols;
    logic [1:0]       r_col_idx;
    logic [3:0]       r_cap_rows;
    logic [1:0]       r_cap_row;
    logic [3:0]       r_cmd;
    logic             r_key_valid;

    kp_state_t        w_state_next;
    logic [CNT_W-1:0] w_scan_cnt_next;
    logic [CNT_W-1:0] w_db_cnt_next;
    logic [3:0]       w_cols_next;
    logic [1:0]       w_col_idx_next;
    logic [3:0]       w_cap_rows_next;
    logic [1:0]       w_cap_row_next;
    logic [3:0]       w_cmd_next;
    logic             w_key_valid_next;
    logic             w_advance;
    logic [3:0]       w_rows_s;
    logic [3:0]       w_low;
    logic             w_one_low;
    logic [1:0]       w_row_idx;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_SAT) ? v : v + CNT_W'(1);
    endfunction

    row_sync #(.WIDTH(KP_ROWS)) u_row_sync (
        .clock (clock),
        .reset (reset),
        .i_d   (rows),
        .o_q   (w_rows_s)
    );

    // Exactly-one-low detection and row encoding of the sampled rows.
    assign w_low     = ~w_rows_s;
    assign w_one_low = (w_low != 4'd0) && ((w_low & (w_low - 4'd1)) == 4'd0);

    always_comb begin
        w_row_idx = 2'd0;
        case (w_low)
            4'b0010: w_row_idx = 2'd1;
            4'b0100: w_row_idx = 2'd2;
            4'b1000: w_row_idx = 2'd3;
            default: w_row_idx = 2'd0;
        endcase
    end

    // Next-state, counters, column drive and output register inputs.
    always_comb begin
        w_state_next    = r_state;
        w_scan_cnt_next = r_scan_cnt;
        w_db_cnt_next   = r_db_cnt;
        w_cols_next     = r_cols;
        w_col_idx_next  = r_col_idx;
        w_cap_rows_next = r_cap_rows;
        w_cap_row_next  = r_cap_row;
        w_advance       = 1'b0;

        case (r_state)
            ST_SCAN: begin
                if (r_scan_cnt == SCAN_LAST) begin
                    if (w_one_low) begin
                        w_state_next    = ST_DEBOUNCE;
                        w_cap_rows_next = w_rows_s;
                        w_cap_row_next  = w_row_idx;
                        w_db_cnt_next   = '0;
                        w_scan_cnt_next = '0;
                    end else begin
                        w_advance = 1'b1;
                    end
                end else begin
                    w_scan_cnt_next = sat_inc(r_scan_cnt);
                end
            end
            ST_DEBOUNCE: begin
                if (w_rows_s != r_cap_rows) begin
                    w_state_next = ST_SCAN;
                    w_advance    = 1'b1;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_next  = key_unused(r_cap_row, r_col_idx) ? ST_RELEASE : ST_EMIT;
                    w_db_cnt_next = '0;
                end else begin
                    w_db_cnt_next = sat_inc(r_db_cnt);
                end
            end
            ST_EMIT: begin
                w_state_next  = ST_RELEASE;
                w_db_cnt_next = '0;
            end
            ST_RELEASE: begin
                if (w_rows_s != 4'b1111) begin
                    w_db_cnt_next = '0;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_next = ST_SCAN;
                    w_advance    = 1'b1;
                end else begin
                    w_db_cnt_next = sat_inc(r_db_cnt);
                end
            end
            default: w_state_next = ST_SCAN;
        endcase

        // Leaving a column slot (or an aborted/finished key) moves to the next column.
        if (w_advance) begin
            w_scan_cnt_next = '0;
            w_cols_next     = {r_cols[2:0], r_cols[3]};
            w_col_idx_next  = r_col_idx + 2'd1;
        end

        // Outputs are registered from the next state so cmd aligns with EMIT.
        w_key_valid_next = (w_state_next == ST_EMIT);
        w_cmd_next       = w_key_valid_next ? key_code(r_cap_row, r_col_idx) : CMD_IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_SCAN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_scan_cnt  <= '0;
            r_db_cnt    <= '0;
            r_cols      <= 4'b1110;
            r_col_idx   <= 2'd0;
            r_cap_rows  <= 4'b1111;
            r_cap_row   <= 2'd0;
            r_cmd       <= CMD_IDLE;
            r_key_valid <= 1'b0;
        end else begin
            r_scan_cnt  <= w_scan_cnt_next;
            r_db_cnt    <= w_db_cnt_next;
            r_cols      <= w_cols_next;
            r_col_idx   <= w_col_idx_next;
            r_cap_rows  <= w_cap_rows_next;
            r_cap_row   <= w_cap_row_next;
            r_cmd       <= w_cmd_next;
            r_key_valid <= w_key_valid_next;
        end
    end

    assign cols      = r_cols;
    assign cmd       = r_cmd;
    assign key_valid = r_key_valid;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a 4x4 key matrix model and an
// expected-command queue drained by a negedge monitor.
module tb_keypad_scanner;
    import keypad_pkg::*;

    logic       clock;
    logic       reset;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] cmd;
    logic       key_valid;

    logic [15:0] keys;          // keys[r*4+c] = 1 when pressed
    logic [3:0]  sb[$];
    int          n_pass;
    int          n_fail;
    int          n_total;

    keypad_scanner #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .rows      (rows),
        .cols      (cols),
        .cmd       (cmd),
        .key_valid (key_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // A pressed key pulls its row low while its column is driven low.
    always_comb begin
        rows = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !cols[c]) rows[r] = 1'b0;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic monitor_loop();
        logic [3:0] e;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (key_valid === 1'b1) begin
                    if (sb.size() == 0) begin
                        check("spurious_emit", 8'(key_valid), 8'd0);
                    end else begin
                        e = sb.pop_front();
                        check("emit_code", 8'(cmd), 8'(e));
                    end
                end else begin
                    check("idle_code", 8'(cmd), 8'(CMD_IDLE));
                end
            end
        end
    endtask

    task automatic wait_sb_empty(input int budget, input string tag);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(tag, 8'(sb.size()), 8'd0);
    endtask

    task automatic wait_cols(input logic [3:0] value, input int budget, input string tag);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (cols !== value && n < budget);
        check(tag, 8'(cols), 8'(value));
    endtask

    initial begin
        logic [3:0] cexp;
        logic [3:0] one;
        n_pass  = 0;
        n_fail  = 0;
        n_total = 0;
        keys    = '0;
        reset   = 1'b1;
        one     = 4'b0001;
        fork
            monitor_loop();
        join_none

        // Reset values
        @(negedge clock);
        check("rst_cols", 8'(cols), 8'(4'b1110));
        check("rst_cmd", 8'(cmd), 8'(CMD_IDLE));
        check("rst_valid", 8'(key_valid), 8'd0);
        @(negedge clock);
        reset = 1'b0;

        // Idle rotation, 4 cycles per column
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            cexp = 4'b1111 ^ (one << ((k / 4) % 4));
            check("scan_rotate", 8'(cols), 8'(cexp));
        end

        // r1,c2 held 40 cycles -> 6, then release timing
        keys[6] = 1'b1;
        sb.push_back(4'd6);
        repeat (40) @(negedge clock);
        check("emit_r1c2_seen", 8'(sb.size()), 8'd0);
        check("frozen_r1c2", 8'(cols), 8'(4'b1011));
        keys[6] = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clock);
            check("release_hold", 8'(cols), 8'(4'b1011));
        end
        @(negedge clock);
        check("release_resume", 8'(cols), 8'(4'b0111));
        repeat (8) @(negedge clock);

        // r3,c2 with bounce -> one 14
        sb.push_back(CMD_EQ);
        keys[14] = 1'b1;
        @(negedge clock);
        keys[14] = 1'b0;
        @(negedge clock);
        keys[14] = 1'b1;
        @(negedge clock);
        keys[14] = 1'b0;
        @(negedge clock);
        keys[14] = 1'b1;
        repeat (30) @(negedge clock);
        wait_sb_empty(10, "emit_r3c2_bounce");
        keys[14] = 1'b0;
        repeat (20) @(negedge clock);

        // r0,c0 + r2,c0 -> no emit and scanning continues; release r2 -> 1
        keys[0] = 1'b1;
        keys[8] = 1'b1;
        wait_cols(4'b1110, 40, "two_key_col0");
        wait_cols(4'b1101, 40, "two_key_scans");
        repeat (20) @(negedge clock);
        keys[8] = 1'b0;
        sb.push_back(4'd1);
        repeat (30) @(negedge clock);
        wait_sb_empty(10, "emit_r0c0");
        keys[0] = 1'b0;
        repeat (20) @(negedge clock);

        // Unused r3,c3 -> frozen in release, no emit; then r0,c3 -> 10
        keys[15] = 1'b1;
        repeat (30) @(negedge clock);
        check("unused_frozen", 8'(cols), 8'(4'b0111));
        keys[15] = 1'b0;
        repeat (20) @(negedge clock);
        keys[3] = 1'b1;
        sb.push_back(CMD_ADD);
        repeat (30) @(negedge clock);
        wait_sb_empty(10, "emit_r0c3");
        keys[3] = 1'b0;
        repeat (20) @(negedge clock);

        // Reset during debounce of r2,c1; key still held -> 8 afterwards
        wait_cols(4'b0111, 40, "pre_r2c1_col3");
        keys[9] = 1'b1;
        wait_cols(4'b1101, 40, "r2c1_col1");
        repeat (5) @(negedge clock);
        check("debounce_frozen", 8'(cols), 8'(4'b1101));
        reset = 1'b1;
        #1;
        check("midrst_cols", 8'(cols), 8'(4'b1110));
        check("midrst_cmd", 8'(cmd), 8'(CMD_IDLE));
        check("midrst_valid", 8'(key_valid), 8'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        sb.push_back(4'd8);
        wait_sb_empty(60, "emit_r2c1_after_rst");
        keys[9] = 1'b0;
        repeat (20) @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
